// File: rtl/nrf_ce_if.sv
// nrf_ce_if: Avalon-MM slave register bus for the nRF24L01 CE sequencer
interface nrf_ce_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nrf_ce_sequencer.sv
// nrf_ce_sequencer: hardware-timed nRF24L01 CE pulse/RX-hold sequencer; define NRF_CE_TIMEOUT_EN for the WAIT_IRQ timeout
module nrf_ce_sequencer #(
  parameter logic [15:0] PULSE_DEFAULT = 16'd500,
  parameter logic [23:0] TIMEOUT_DEFAULT = 24'd50000
) (
  input  logic     clk,
  input  logic     reset_n,
  nrf_ce_if.slave  bus,
  input  logic     nrf_irq_n,
  output logic     ce_out,
  output logic     irq
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT_IRQ, RX_ON} state_t;
  state_t state, state_nx;
  logic [15:0] pulse_len, cnt, cnt_nx;
  logic [3:0] status, set, clr;
  logic [1:0] sync;
  logic wr, ctrl_wr, tx, rx, ab, busy, rx_active, irq_low, unused;
`ifdef NRF_CE_TIMEOUT_EN
  logic [23:0] timeout, tlim, tlim_nx, tcnt, tcnt_nx;
`endif
  assign wr = bus.chipselect && !bus.write_n;
  assign ctrl_wr = wr && bus.address == 2'd0;
  assign tx = bus.writedata[0];
  assign rx = bus.writedata[1];
  assign ab = bus.writedata[2];
  assign clr = (wr && bus.address == 2'd2) ? bus.writedata[3:0] : 4'd0;
  assign irq_low = !sync[1];
  assign unused = ^{bus.writedata[31:16], TIMEOUT_DEFAULT};
  // two-flop synchronizer for the radio IRQ pin, idles high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= 2'b11;
    else sync <= {sync[0], nrf_irq_n};
  // config registers, sticky W1C status (set beats clear) and registered CPU interrupt
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pulse_len <= PULSE_DEFAULT;
      status <= 4'd0;
      irq <= 1'b0;
`ifdef NRF_CE_TIMEOUT_EN
      timeout <= TIMEOUT_DEFAULT;
`endif
    end else begin
      if (wr && bus.address == 2'd1) pulse_len <= bus.writedata[15:0];
`ifdef NRF_CE_TIMEOUT_EN
      if (wr && bus.address == 2'd3) timeout <= bus.writedata[23:0];
`endif
      status <= (status & ~clr) | set;
      irq <= status[0] | status[2] | status[3];
    end
  // state register and sequence counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 16'd0;
`ifdef NRF_CE_TIMEOUT_EN
      tlim <= 24'd0;
      tcnt <= 24'd0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
`ifdef NRF_CE_TIMEOUT_EN
      tlim <= tlim_nx;
      tcnt <= tcnt_nx;
`endif
    end
  // next state, counter loads and status set events; ABORT overrides everything
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    set = 4'd0;
`ifdef NRF_CE_TIMEOUT_EN
    tlim_nx = tlim;
    tcnt_nx = tcnt;
`endif
    if (ctrl_wr && ab) state_nx = IDLE;
    else case (state)
      IDLE:
        if (ctrl_wr && tx) begin
          state_nx = PULSE;
          cnt_nx = pulse_len == 16'd0 ? 16'd0 : pulse_len - 16'd1;
`ifdef NRF_CE_TIMEOUT_EN
          tlim_nx = timeout;
`endif
        end else if (ctrl_wr && rx) state_nx = RX_ON;
      PULSE: begin
        set[3] = ctrl_wr && (tx || rx);
        if (cnt == 16'd0) begin
          state_nx = WAIT_IRQ;
`ifdef NRF_CE_TIMEOUT_EN
          tcnt_nx = 24'd0;
`endif
        end else cnt_nx = cnt - 16'd1;
      end
      WAIT_IRQ: begin
        set[3] = ctrl_wr && (tx || rx);
        if (irq_low) begin
          state_nx = IDLE;
          set[1:0] = 2'b11;
        end
`ifdef NRF_CE_TIMEOUT_EN
        else if (tlim != 24'd0 && tcnt + 24'd1 == tlim) begin
          state_nx = IDLE;
          set[2] = 1'b1;
          set[0] = 1'b1;
        end else tcnt_nx = tcnt + 24'd1;
`endif
      end
      default: begin
        set[3] = ctrl_wr && (tx || rx);
        if (ctrl_wr && !rx) state_nx = IDLE;
      end
    endcase
  end
  // CE is decoded straight from state so reset drops it asynchronously
  always_comb begin
    ce_out = state == PULSE || state == RX_ON;
    busy = state != IDLE;
    rx_active = state == RX_ON;
  end
  // zero-wait-state read mux
  always_comb begin
`ifdef NRF_CE_TIMEOUT_EN
    bus.readdata = bus.address == 2'd3 ? {8'd0, timeout} : 32'd0;
`else
    bus.readdata = 32'd0;
`endif
    bus.readdata = bus.address == 2'd0 ? {29'd0, ce_out, rx_active, busy} :
                   bus.address == 2'd1 ? {16'd0, pulse_len} :
                   bus.address == 2'd2 ? {28'd0, status} : bus.readdata;
  end
endmodule
